// File: rtl/tdm_demux8_if.sv
//------------------------------------------------------------------------------
// Module  : tdm_demux8_if
// Brief   : Serial-in / parallel-out bundle for the TDM demultiplexer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface tdm_demux8_if #(
    parameter int NCH   = 8,
    parameter int CNT_W = 8
);
    logic             din;
    logic             din_valid;
    logic             fs;
    logic [NCH-1:0]   y;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;
    logic             par_err;
    logic [CNT_W-1:0] frame_cnt;

    modport master (
        output din, din_valid, fs,
        input  y, frame_valid, locked, sync_err, par_err, frame_cnt
    );

    modport slave (
        input  din, din_valid, fs,
        output y, frame_valid, locked, sync_err, par_err, frame_cnt
    );
endinterface

`default_nettype wire

// File: rtl/tdm_demux8.sv
//------------------------------------------------------------------------------
// Module  : tdm_demux8
// Brief   : Frame-synced serial-to-parallel TDM demux with lock/error status.
//           Define TDM_DEMUX_PARITY_EN to append an even-parity slot per frame.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tdm_demux8 #(
    parameter int NCH   = 8,
    parameter int SEL_W = 3,
    parameter int CNT_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    tdm_demux8_if.slave     bus
);

`ifdef TDM_DEMUX_PARITY_EN
    localparam int c_flen = NCH + 1;
`else
    localparam int c_flen = NCH;
`endif
    // Widened if needed so the parity slot index always fits.
    localparam int c_slot_w = (SEL_W > $clog2(c_flen)) ? SEL_W : $clog2(c_flen);
    localparam logic [c_slot_w-1:0] c_last = c_slot_w'(c_flen - 1);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t              r_state,  w_state_nxt;
    logic [c_slot_w-1:0] r_slot,   w_slot_nxt;
    logic [NCH-1:0]      r_shadow, w_shadow_nxt;
    logic [NCH-1:0]      r_y,      w_y_nxt;
    logic                r_frame_valid, w_frame_valid_nxt;
    logic                r_locked,      w_locked_nxt;
    logic                r_sync_err,    w_sync_err_nxt;
    logic                r_par_err,     w_par_err_nxt;
    logic [CNT_W-1:0]    r_frame_cnt,   w_frame_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_slot        <= '0;
            r_shadow      <= '0;
            r_y           <= '0;
            r_frame_valid <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_err    <= 1'b0;
            r_par_err     <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_slot        <= w_slot_nxt;
            r_shadow      <= w_shadow_nxt;
            r_y           <= w_y_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_locked      <= w_locked_nxt;
            r_sync_err    <= w_sync_err_nxt;
            r_par_err     <= w_par_err_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_slot_nxt        = r_slot;
        w_shadow_nxt      = r_shadow;
        w_y_nxt           = r_y;
        w_frame_valid_nxt = 1'b0;
        w_locked_nxt      = r_locked;
        w_sync_err_nxt    = 1'b0;
        w_par_err_nxt     = 1'b0;
        w_frame_cnt_nxt   = r_frame_cnt;

        if (bus.din_valid) begin
            case (r_state)
                HUNT: begin
                    if (bus.fs) begin
                        w_shadow_nxt    = '0;
                        w_shadow_nxt[0] = bus.din;
                        w_slot_nxt      = c_slot_w'(1);
                        w_state_nxt     = RECV;
                    end
                end
                default: begin
                    if (r_slot == '0) begin
                        if (bus.fs) begin
                            w_shadow_nxt    = '0;
                            w_shadow_nxt[0] = bus.din;
                            w_slot_nxt      = c_slot_w'(1);
                        end else begin
                            w_sync_err_nxt = 1'b1;
                            w_locked_nxt   = 1'b0;
                            w_slot_nxt     = '0;
                            w_state_nxt    = HUNT;
                        end
                    end else if (bus.fs) begin
                        // Premature sync restarts the frame on this very beat.
                        w_sync_err_nxt  = 1'b1;
                        w_locked_nxt    = 1'b0;
                        w_shadow_nxt    = '0;
                        w_shadow_nxt[0] = bus.din;
                        w_slot_nxt      = c_slot_w'(1);
                    end else if (r_slot == c_last) begin
                        w_slot_nxt = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        if (^{r_shadow, bus.din} == 1'b0) begin
                            w_y_nxt           = r_shadow;
                            w_frame_valid_nxt = 1'b1;
                            w_frame_cnt_nxt   = r_frame_cnt + 1'b1;
                            w_locked_nxt      = 1'b1;
                        end else begin
                            w_par_err_nxt = 1'b1;
                        end
`else
                        w_y_nxt           = {bus.din, r_shadow[NCH-2:0]};
                        w_frame_valid_nxt = 1'b1;
                        w_frame_cnt_nxt   = r_frame_cnt + 1'b1;
                        w_locked_nxt      = 1'b1;
`endif
                    end else begin
                        for (int k = 0; k < NCH; k++) begin
                            if (r_slot == c_slot_w'(k)) begin
                                w_shadow_nxt[k] = bus.din;
                            end
                        end
                        w_slot_nxt = r_slot + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.y           = r_y;
    assign bus.frame_valid = r_frame_valid;
    assign bus.locked      = r_locked;
    assign bus.sync_err    = r_sync_err;
    assign bus.frame_cnt   = r_frame_cnt;
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.par_err     = r_par_err;
`else
    assign bus.par_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux8.sv
//------------------------------------------------------------------------------
// Module  : tb_tdm_demux8
// Brief   : Directed scoreboard bench for tdm_demux8.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tdm_demux8;
    localparam int NCH   = 8;
    localparam int CNT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdm_demux8_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    tdm_demux8 #(.NCH(NCH), .SEL_W(3), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int             n_cmp  = 0;
    int             n_err  = 0;
    int             n_sync = 0;
    int             n_par  = 0;
    logic [7:0]     exp_cnt = '0;
    logic [15:0]    sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops an expected {y, frame_cnt} per frame_valid pulse.
    always @(negedge clk) begin
        logic [15:0] e;
        if (bus.sync_err === 1'b1) n_sync++;
        if (bus.par_err === 1'b1) n_par++;
        if (bus.frame_valid === 1'b1 || bus.sync_err === 1'b1)
            chk("fv_sync_excl", 32'(bus.frame_valid & bus.sync_err), 32'd0);
        if (bus.frame_valid === 1'b1) begin
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_err++;
                $error("FAIL unexpected_frame: observed y=%0h expected no frame", bus.y);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("y", 32'(bus.y), 32'(e[15:8]));
                chk("frame_cnt", 32'(bus.frame_cnt), 32'(e[7:0]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic d, input logic f);
        bus.din       = d;
        bus.fs        = f;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
        bus.fs        = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] v, input bit gaps, input bit bad_par,
                              input logic [7:0] hold);
        if (!bad_par) begin
            exp_cnt++;
            sb.push_back({v, exp_cnt});
        end
        for (int k = 0; k < NCH; k++) begin
            if (gaps && k > 0 && $urandom_range(0, 1) == 1) begin
                idle(1 + $urandom_range(0, 1));
                chk("y_hold_gap", 32'(bus.y), 32'(hold));
            end
            beat(v[k], k == 0);
        end
`ifdef TDM_DEMUX_PARITY_EN
        beat((^v) ^ bad_par, 1'b0);
`endif
    endtask

    initial begin
        int s0;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.fs        = 1'b0;

        // Reset values
        idle(2);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_fv", 32'(bus.frame_valid), 32'd0);
        chk("rst_locked", 32'(bus.locked), 32'd0);
        chk("rst_sync_err", 32'(bus.sync_err), 32'd0);
        chk("rst_par_err", 32'(bus.par_err), 32'd0);
        chk("rst_cnt", 32'(bus.frame_cnt), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic frame
        send_frame(8'h4D, 1'b0, 1'b0, 8'h00);
        idle(2);
        chk("f1_y", 32'(bus.y), 32'h4D);
        chk("f1_locked", 32'(bus.locked), 32'd1);
        chk("f1_cnt", 32'(bus.frame_cnt), 32'd1);

        // Back-to-back frames with valid gaps
        send_frame(8'hA5, 1'b1, 1'b0, 8'h4D);
        send_frame(8'h3C, 1'b1, 1'b0, 8'hA5);
        idle(2);
        chk("b2b_y", 32'(bus.y), 32'h3C);
        chk("b2b_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));

        // Premature sync in slot 4
        send_frame(8'hFF, 1'b0, 1'b0, 8'h3C);
        s0 = n_sync;
        beat(1'b0, 1'b1);
        for (int k = 1; k < 4; k++) beat(1'b1, 1'b0);
        exp_cnt++;
        sb.push_back({8'h01, exp_cnt});
        beat(1'b1, 1'b1);
        chk("pre_sync_err", 32'(bus.sync_err), 32'd1);
        chk("pre_locked", 32'(bus.locked), 32'd0);
        chk("pre_y_hold", 32'(bus.y), 32'hFF);
        for (int k = 1; k < NCH; k++) beat(1'b0, 1'b0);
`ifdef TDM_DEMUX_PARITY_EN
        beat(1'b1, 1'b0);
`endif
        idle(2);
        chk("pre_y_next", 32'(bus.y), 32'h01);
        chk("pre_relock", 32'(bus.locked), 32'd1);
        chk("pre_nsync", 32'(n_sync - s0), 32'd1);

        // Missing sync on slot 0, then HUNT ignores unsynced beats
        beat(1'b1, 1'b0);
        chk("miss_sync_err", 32'(bus.sync_err), 32'd1);
        chk("miss_locked", 32'(bus.locked), 32'd0);
        idle(1);
        s0 = n_sync;
        repeat (3) beat(1'b1, 1'b0);
        idle(2);
        chk("hunt_nsync", 32'(n_sync - s0), 32'd0);
        chk("hunt_y", 32'(bus.y), 32'h01);
        chk("hunt_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
        send_frame(8'h80, 1'b0, 1'b0, 8'h01);
        idle(2);
        chk("hunt_rec_y", 32'(bus.y), 32'h80);
        chk("hunt_rec_locked", 32'(bus.locked), 32'd1);

        // Reset at slot 5
        beat(1'b1, 1'b1);
        for (int k = 1; k < 5; k++) beat(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_y", 32'(bus.y), 32'd0);
        chk("mrst_locked", 32'(bus.locked), 32'd0);
        chk("mrst_cnt", 32'(bus.frame_cnt), 32'd0);
        exp_cnt = '0;
        idle(1);
        rst_n = 1'b1;
        s0 = n_sync;
        repeat (3) beat(1'b1, 1'b0);
        idle(2);
        chk("mrst_no_partial", 32'(bus.y), 32'd0);
        chk("mrst_nsync", 32'(n_sync - s0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 8'h00);
        idle(2);
        chk("mrst_rec_y", 32'(bus.y), 32'h5A);
        chk("mrst_rec_cnt", 32'(bus.frame_cnt), 32'd1);

`ifdef TDM_DEMUX_PARITY_EN
        // Parity accept then reject
        send_frame(8'h4D, 1'b0, 1'b0, 8'h5A);
        send_frame(8'h4D, 1'b0, 1'b1, 8'h4D);
        chk("par_err", 32'(bus.par_err), 32'd1);
        idle(2);
        chk("par_y_hold", 32'(bus.y), 32'h4D);
        chk("par_cnt_hold", 32'(bus.frame_cnt), 32'(exp_cnt));
        chk("par_locked", 32'(bus.locked), 32'd1);
        chk("par_count", 32'(n_par), 32'd1);
`endif

        // Counter wrap
        repeat (256) send_frame(8'($urandom), 1'b0, 1'b0, 8'h00);
        idle(3);
        chk("wrap_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire
